// File: rtl/km_pkg.sv
// rtl/km_pkg.sv - shared constants and types for the km multiplier/reducer family
// Purpose: default residue width, fold constant, modulus and word types shared
//          by km_rtl, km_modred_pipe and their benches.
// Ports:   none (package).
package km_pkg;

    localparam int WORD_LEN = 14;
    localparam int C        = 3;
    localparam int TAG_W    = 4;
    localparam int Q_VAL    = (1 << WORD_LEN) - C;

    typedef logic [WORD_LEN-1:0]   residue_t;
    typedef logic [2*WORD_LEN-1:0] prod_t;

endpackage

// File: rtl/km_fold.sv
// rtl/km_fold.sv - combinational pseudo-Mersenne fold dout = lo + C*hi
// Purpose: one folding step for Q = 2^WL - CF. Since 2^WL == CF (mod Q), the
//          bits at and above WL can be replaced by CF times their value.
// Ports:
//   din   in   IN_W   value to fold; low WL bits are lo, the rest is hi
//   dout  out  OUT_W  lo + CF*hi; OUT_W must be wide enough for the sum
module km_fold #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 17,
    parameter int WL    = 14,
    parameter int CF    = 3
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    logic [OUT_W-1:0] lo_ext;
    logic [OUT_W-1:0] hi_ext;

    assign lo_ext = OUT_W'(din[WL-1:0]);
    assign hi_ext = OUT_W'(din[IN_W-1:WL]);
    assign dout   = lo_ext + OUT_W'(CF) * hi_ext;

endmodule

// File: rtl/km_modred_pipe.sv
// rtl/km_modred_pipe.sv - three-stage pipelined reduction of a raw product mod 2^WORD_LEN - C
// Purpose: S1 folds the 2*WORD_LEN product, S2 folds again, S3 does the final
//          conditional subtract. One global stall keeps every stage in lockstep.
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   in_valid   in   1            in_prod/in_tag valid
//   in_ready   out  1            stage accepts this cycle
//   in_prod    in   2*WORD_LEN   raw product
//   in_tag     in   TAG_W        sideband tag, returned unchanged
//   out_valid  out  1            out_res/out_tag valid
//   out_ready  in   1            consumer accepts this cycle
//   out_res    out  WORD_LEN     in_prod mod Q
//   out_tag    out  TAG_W        tag of the presented result
module km_modred_pipe #(
    parameter int WORD_LEN = km_pkg::WORD_LEN,
    parameter int C        = km_pkg::C,
    parameter int TAG_W    = km_pkg::TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*WORD_LEN-1:0] in_prod,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_LEN-1:0]   out_res,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int X1_W = WORD_LEN + 3;
    localparam int X2_W = WORD_LEN + 1;
    localparam logic [X2_W-1:0] Q_EXT = X2_W'((1 << WORD_LEN) - C);

    logic              v1, v2, v3;
    logic [X1_W-1:0]   x1;
    logic [X2_W-1:0]   x2;
    logic [TAG_W-1:0]  t1, t2;

    logic              adv;
    logic [X1_W-1:0]   fold1;
    logic [X2_W-1:0]   fold2;
    logic [X2_W-1:0]   corr;

    // Whole pipe moves together; bubbles are not squeezed out under a stall.
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    km_fold #(.IN_W(2*WORD_LEN), .OUT_W(X1_W), .WL(WORD_LEN), .CF(C)) u_fold1 (
        .din  (in_prod),
        .dout (fold1)
    );

    km_fold #(.IN_W(X1_W), .OUT_W(X2_W), .WL(WORD_LEN), .CF(C)) u_fold2 (
        .din  (x1),
        .dout (fold2)
    );

    // After two folds x2 < 2^WL + 7C < 2Q for C <= 7, so one subtract suffices.
    assign corr = (x2 >= Q_EXT) ? (x2 - Q_EXT) : x2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            x1      <= '0;
            x2      <= '0;
            t1      <= '0;
            t2      <= '0;
            out_res <= '0;
            out_tag <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            // Data only follows a valid source so idle slots never load garbage.
            if (in_valid) begin
                x1 <= fold1;
                t1 <= in_tag;
            end
            if (v1) begin
                x2 <= fold2;
                t2 <= t1;
            end
            if (v2) begin
                out_res <= corr[WORD_LEN-1:0];
                out_tag <= t2;
            end
        end
    end

endmodule

// File: tb/tb_km_modred_pipe.sv
// tb/tb_km_modred_pipe.sv - self-checking bench for km_modred_pipe against a mod-Q scoreboard
module tb_km_modred_pipe;
    import km_pkg::*;

    localparam int N_RAND = 30000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [2*WORD_LEN-1:0] in_prod;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_LEN-1:0]   out_res;
    logic [TAG_W-1:0]      out_tag;

    km_modred_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint exp_res_q[$];
    int     exp_tag_q[$];

    bit     acc, pop;
    int     pop_tag, pop_res;
    bit     hold_v = 1'b0;
    int     hold_res, hold_tag;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then advance past the edge.
    task automatic step();
        longint e_res;
        int     e_tag;
        acc = 1'b0;
        pop = 1'b0;
        @(negedge clk);
        #1;
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_res", out_res, hold_res);
            chk("hold_tag", out_tag, hold_tag);
        end
        if (out_valid && out_ready) begin
            pop     = 1'b1;
            pop_res = int'(out_res);
            pop_tag = int'(out_tag);
            chk("pop_has_expect", exp_res_q.size() > 0, 1);
            if (exp_res_q.size() > 0) begin
                e_res = exp_res_q.pop_front();
                e_tag = exp_tag_q.pop_front();
                chk("res", out_res, e_res);
                chk("tag", out_tag, e_tag);
            end
        end
        hold_v   = out_valid && !out_ready;
        hold_res = int'(out_res);
        hold_tag = int'(out_tag);
        if (in_valid && in_ready) begin
            acc = 1'b1;
            exp_res_q.push_back(longint'(in_prod) % Q_VAL);
            exp_tag_q.push_back(int'(in_tag));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_item(input longint p, input int t);
        int guard = 0;
        in_prod  = (2*WORD_LEN)'(p);
        in_tag   = TAG_W'(t);
        in_valid = 1'b1;
        do begin
            step();
            guard++;
        end while (!acc && guard < 50);
        chk("push_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(output int last_res, output int last_tag);
        int guard = 0;
        last_res = -1;
        last_tag = -1;
        while (exp_res_q.size() > 0 && guard < 50) begin
            step();
            if (pop) begin
                last_res = pop_res;
                last_tag = pop_tag;
            end
            guard++;
        end
        chk("drain_empty", exp_res_q.size(), 0);
    endtask

    task automatic check_value(input longint p, input int t, input int want);
        int r, tg;
        push_item(p, t);
        drain(r, tg);
        chk("dir_res", r, want);
        chk("dir_tag", tg, t);
    endtask

    initial begin
        int r, tg, lat, accepts, cur_tag, npop, first_pop, k, cyc, sent, after;
        int ptags[$];
        longint a, b, p;

        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_tag = '0; out_ready = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_res", out_res, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: idle after reset
        chk("idle_valid", out_valid, 0);
        chk("idle_res", out_res, 0);
        chk("idle_tag", out_tag, 0);
        chk("idle_in_ready", in_ready, 1);

        // 2: latency and simple values
        in_prod = '0; in_tag = 4'd1; in_valid = 1'b1;
        step();
        chk("lat_accept", acc, 1);
        in_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!pop && lat < 10);
        chk("latency", lat, 3);
        chk("zero_res", pop_res, 0);
        check_value(16384, 2, 3);
        check_value(16381, 3, 0);

        // 3: boundary products
        check_value(268304400, 5, 1);
        check_value(268435455, 6, 8);
        check_value(longint'(Q_VAL) * 16000, 7, 0);

        // 4: stall with a full pipe, then release
        out_ready = 1'b0;
        cur_tag   = 1;
        accepts   = 0;
        in_valid  = 1'b1;
        in_prod   = 28'd100;
        in_tag    = 4'd1;
        repeat (5) begin
            step();
            if (acc) begin
                accepts++;
                cur_tag++;
                in_tag  = TAG_W'(cur_tag);
                in_prod = 28'(100 * cur_tag);
            end
        end
        chk("stall_accepts", accepts, 3);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_held_tag", in_tag, 4);
        out_ready = 1'b1;
        npop = 0; first_pop = -1; k = 0;
        ptags.delete();
        while (npop < 4 && k < 20) begin
            step();
            if (acc) in_valid = 1'b0;
            if (pop) begin
                if (first_pop < 0) first_pop = k;
                ptags.push_back(pop_tag);
                npop++;
            end
            k++;
        end
        chk("release_pops", npop, 4);
        chk("release_consecutive", k - first_pop, 4);
        for (int i = 0; i < ptags.size(); i++) chk("release_order", ptags[i], i + 1);
        chk("release_drained", exp_res_q.size(), 0);

        // 5: reset with items in flight
        in_valid = 1'b1;
        accepts  = 0;
        for (int i = 0; i < 3; i++) begin
            in_prod = 28'(5000 + i);
            in_tag  = TAG_W'(8 + i);
            step();
            if (acc) accepts++;
        end
        in_valid = 1'b0;
        chk("inflight_accepts", accepts, 3);
        chk("inflight_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_res", out_res, 0);
        chk("midrst_tag", out_tag, 0);
        exp_res_q.delete();
        exp_tag_q.delete();
        hold_v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_item(20000, 12);
        npop = 0;
        repeat (8) begin
            step();
            if (pop) npop++;
        end
        chk("post_rst_pops", npop, 1);
        chk("post_rst_res", pop_res, 20000 % Q_VAL);

        // 6: random products with random back-pressure
        sent = 0; cyc = 0;
        in_valid = 1'b0;
        while ((sent < N_RAND || exp_res_q.size() > 0 || in_valid) && cyc < 95000) begin
            if (!in_valid && sent < N_RAND && $urandom_range(0, 9) < 8) begin
                a = longint'($urandom_range(1, Q_VAL));
                b = longint'($urandom_range(1, Q_VAL));
                p = (sent % 8 == 7) ? longint'($urandom & 32'h0FFF_FFFF) : a * b;
                in_prod  = (2*WORD_LEN)'(p);
                in_tag   = TAG_W'(sent);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rand_sent", sent, N_RAND);
        chk("rand_drained", exp_res_q.size(), 0);
        after = 0;
        out_ready = 1'b1;
        repeat (4) begin
            step();
            if (pop) after++;
        end
        chk("rand_no_extra", after, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
